ov7670_capture: RTL and testbench

//  Sensor-side capture stage. Samples the OV7670 8-bit parallel bus (VSYNC/HREF/D) and

---
 rtl/ov7670_capture_if.sv | 23 ++
 rtl/ov7670_capture.sv | 192 +++++++++++++++++++
 tb/tb_ov7670_capture.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_capture_if.sv
// Pixel stream from the OV7670 capture stage to its consumers (grayscale converter, frame-buffer writer).
interface ov7670_capture_if #(
  parameter int unsigned ADDR_W = 19
);
  logic [15:0]       pix_data;
  logic              pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic [9:0]        pix_x;
  logic [9:0]        pix_y;
  logic              frame_start;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output pix_data, pix_valid, pix_addr, pix_x, pix_y,
    output frame_start, frame_done, frame_err
  );

  modport slave (
    input pix_data, pix_valid, pix_addr, pix_x, pix_y,
    input frame_start, frame_done, frame_err
  );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 capture: samples VSYNC/HREF/D, pairs bytes into RGB565 pixels with address and frame markers.
// Optional 2:1 decimation on both axes when CAPTURE_DECIMATE_EN is defined.
module ov7670_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_d,
  ov7670_capture_if.master pix
);

  localparam logic [9:0]        H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIM    = 10'(V_ACTIVE);
  localparam logic [9:0]        CNT_MAX  = 10'h3FF;
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {SYNC, FRAME, BLANK} state_t;

  state_t            state_q, state_d;

  logic              vsync_s1_q, vsync_s1_d;
  logic              href_s1_q, href_s1_d;
  logic [7:0]        d_s1_q, d_s1_d;
  logic              vsync_p_q, vsync_p_d;
  logic              href_p_q, href_p_d;

  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;

  logic [15:0]       pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [9:0]        pix_x_q, pix_x_d;
  logic [9:0]        pix_y_q, pix_y_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;

  logic              vs_fall, vs_rise, href_fall;
  logic              keep;
  logic [9:0]        out_x, out_y;

  assign vs_fall   = vsync_p_q & ~vsync_s1_q;
  assign vs_rise   = ~vsync_p_q & vsync_s1_q;
  assign href_fall = href_p_q & ~href_s1_q;

  always_comb begin
    keep  = 1'b0;
    out_x = '0;
    out_y = '0;
`ifdef CAPTURE_DECIMATE_EN
    keep  = (x_q < H_LIM) && (y_q < V_LIM) && !x_q[0] && !y_q[0];
    out_x = {1'b0, x_q[9:1]};
    out_y = {1'b0, y_q[9:1]};
`else
    keep  = (x_q < H_LIM) && (y_q < V_LIM);
    out_x = x_q;
    out_y = y_q;
`endif
  end

  always_comb begin
    vsync_s1_d    = cam_vsync;
    href_s1_d     = cam_href;
    d_s1_d        = cam_d;
    vsync_p_d     = vsync_s1_q;
    href_p_d      = href_s1_q;

    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    phase_d       = phase_q;
    hi_d          = hi_q;

    pix_data_d    = pix_data_q;
    pix_valid_d   = 1'b0;
    pix_addr_d    = pix_addr_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = frame_err_q;

    unique case (state_q)
      SYNC, BLANK: begin
        if (vs_fall) begin
          state_d       = FRAME;
          frame_start_d = 1'b1;
          x_d           = '0;
          y_d           = '0;
          addr_d        = '0;
          phase_d       = 1'b0;
          frame_err_d   = 1'b0;
        end
      end
      FRAME: begin
        // VSYNC rising wins over a simultaneous HREF byte: that byte is dropped.
        if (vs_rise) begin
          state_d      = BLANK;
          frame_done_d = 1'b1;
          phase_d      = 1'b0;
          x_d          = '0;
          if (y_q != V_LIM) frame_err_d = 1'b1;
        end else if (href_s1_q) begin
          if (!phase_q) begin
            hi_d = d_s1_q;
          end else begin
            if (keep) begin
              pix_valid_d = 1'b1;
              pix_data_d  = {hi_q, d_s1_q};
              pix_addr_d  = addr_q;
              pix_x_d     = out_x;
              pix_y_d     = out_y;
              if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_W'(1);
            end
            if (x_q != CNT_MAX) x_d = x_q + 10'd1;
          end
          phase_d = ~phase_q;
        end else if (href_fall) begin
          if (phase_q) frame_err_d = 1'b1;
          if (x_q != H_LIM) frame_err_d = 1'b1;
          x_d     = '0;
          phase_d = 1'b0;
          if (y_q != CNT_MAX) y_d = y_q + 10'd1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SYNC;
      vsync_s1_q    <= 1'b0;
      href_s1_q     <= 1'b0;
      d_s1_q        <= '0;
      vsync_p_q     <= 1'b0;
      href_p_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_addr_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_s1_q    <= vsync_s1_d;
      href_s1_q     <= href_s1_d;
      d_s1_q        <= d_s1_d;
      vsync_p_q     <= vsync_p_d;
      href_p_q      <= href_p_d;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      pix_addr_q    <= pix_addr_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign pix.pix_data    = pix_data_q;
  assign pix.pix_valid   = pix_valid_q;
  assign pix.pix_addr    = pix_addr_q;
  assign pix.pix_x       = pix_x_q;
  assign pix.pix_y       = pix_y_q;
  assign pix.frame_start = frame_start_q;
  assign pix.frame_done  = frame_done_q;
  assign pix.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized scoreboard bench for ov7670_capture; reference model builds expected pixels per frame.
`timescale 1ns/1ps
module tb_ov7670_capture;

`ifdef CAPTURE_DECIMATE_EN
  localparam int unsigned H   = 8;
  localparam int unsigned V   = 4;
  localparam bit          DEC = 1'b1;
`else
  localparam int unsigned H   = 4;
  localparam int unsigned V   = 2;
  localparam bit          DEC = 1'b0;
`endif
  localparam int unsigned AW = 19;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_d;

  always #5 pclk = ~pclk;

  ov7670_capture_if #(.ADDR_W(AW)) pix ();

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_d     (cam_d),
    .pix       (pix)
  );

  typedef struct packed {
    logic [15:0]   data;
    logic [AW-1:0] addr;
    logic [9:0]    x;
    logic [9:0]    y;
  } pix_t;

  pix_t       exp_q[$];
  bit         exp_err_q[$];
  int         lens_q[$];
  int         tests = 0;
  int         fails = 0;
  int         starts_exp = 0;
  int         starts_seen = 0;
  pix_t       mon_e;
  bit         mon_err;
  logic [7:0] pat [8] = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a pixel or frame marker.
  initial begin
    forever begin
      @(negedge pclk);
      if (rst_n === 1'b1) begin
        if (pix.pix_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pixel", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("pix_data", pix.pix_data, mon_e.data);
            check("pix_addr", pix.pix_addr, mon_e.addr);
            check("pix_x", pix.pix_x, mon_e.x);
            check("pix_y", pix.pix_y, mon_e.y);
          end
        end
        if (pix.frame_start === 1'b1) begin
          starts_seen++;
          check("err_clear_at_start", pix.frame_err, 0);
        end
        if (pix.frame_done === 1'b1) begin
          if (exp_err_q.size() == 0) begin
            check("unexpected_frame_done", 1, 0);
          end else begin
            mon_err = exp_err_q.pop_front();
            check("frame_err_at_done", pix.frame_err, mon_err);
          end
        end
      end
    end
  end

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge pclk);
    cam_vsync = vs;
    cam_href  = hr;
    cam_d     = d;
  endtask

  task automatic set_lines(input int n, input int len);
    lens_q = {};
    for (int j = 0; j < n; j++) lens_q.push_back(len);
  endtask

  // One frame from lens_q; abort_line >= 0 raises VSYNC with HREF high after abort_byte bytes.
  task automatic send_frame(input int abort_line, input int abort_byte, input bit fixed);
    int  lines_done;
    int  addr;
    bit  err;
    bit  aborted;
    int  n;
    int  used;
    logic [7:0] b[$];
    lines_done = 0;
    addr       = 0;
    err        = 1'b0;
    aborted    = 1'b0;
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    starts_exp++;
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    for (int j = 0; j < lens_q.size() && !aborted; j++) begin
      n       = lens_q[j];
      aborted = (j == abort_line);
      used    = aborted ? abort_byte : n;
      b       = {};
      for (int i = 0; i < used; i++) b.push_back(fixed ? pat[i % 8] : 8'($urandom));
      for (int p = 0; p < used / 2; p++) begin
        if (p < int'(H) && j < int'(V) && (!DEC || (p % 2 == 0 && j % 2 == 0))) begin
          exp_q.push_back('{data: {b[2*p], b[2*p+1]}, addr: AW'(addr),
                            x: 10'(DEC ? p / 2 : p), y: 10'(DEC ? j / 2 : j)});
          addr++;
        end
      end
      if (!aborted) begin
        lines_done++;
        if ((n % 2) != 0 || (n / 2) != int'(H)) err = 1'b1;
      end
      for (int i = 0; i < used; i++) drive(1'b0, 1'b1, b[i]);
      if (!aborted) repeat (3) drive(1'b0, 1'b0, 8'h00);
    end
    if (lines_done != int'(V)) err = 1'b1;
    exp_err_q.push_back(err);
    if (aborted) drive(1'b1, 1'b1, 8'($urandom));
    repeat (5) drive(1'b1, 1'b0, 8'h00);
    check("frame_err_sticky_in_blank", pix.frame_err, err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nl;
    int  ab_line;
    int  ab_byte;
    int  r;
    bit  found;
    logic [7:0] b0, b1;

    rst_n = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
    repeat (3) @(negedge pclk);
    check("reset_valid", pix.pix_valid, 0);
    check("reset_data", pix.pix_data, 0);
    check("reset_addr", pix.pix_addr, 0);
    check("reset_err", pix.frame_err, 0);
    check("reset_start_done", {pix.frame_start, pix.frame_done}, 0);
    rst_n = 1'b1;

    // Partial frame and blanking lines before any VSYNC fall: nothing may come out.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'($urandom));
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'($urandom));
      repeat (2) drive(1'b1, 1'b0, 8'h00);
    end
    check("no_start_in_sync", starts_seen, 0);

    set_lines(V, 2 * H);             send_frame(-1, 0, 1'b1);   // color pattern, clean
    set_lines(V, 2 * H);             send_frame(-1, 0, 1'b0);   // clean random
    set_lines(V, 2 * H); lens_q[0] = 2 * H + 1; send_frame(-1, 0, 1'b0);  // odd byte count
    set_lines(V, 2 * H); lens_q[0] = 6 * H;     send_frame(-1, 0, 1'b0);  // overlong line
    set_lines(V, 2 * H);             send_frame(1, H, 1'b0);     // VSYNC mid-line at y=1
    set_lines(V + 1, 2 * H);         send_frame(-1, 0, 1'b0);   // extra line dropped
    set_lines(V, 2 * H - 2);         send_frame(-1, 0, 1'b0);   // short lines

    for (int f = 0; f < 20; f++) begin
      nl = int'(V) - 1 + int'($urandom_range(2));
      lens_q = {};
      for (int j = 0; j < nl; j++) begin
        r = int'($urandom_range(9));
        lens_q.push_back(r < 6 ? int'(2 * H) : int'(2 * H) + int'($urandom_range(4)) - 2);
      end
      ab_line = ($urandom_range(3) == 0) ? int'($urandom_range(nl - 1)) : -1;
      ab_byte = int'($urandom_range(2 * H));
      send_frame(ab_line, ab_byte, 1'b0);
    end

    // Asynchronous reset while a pixel is on the outputs.
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    starts_exp++;
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    b0 = 8'($urandom) | 8'h01;
    b1 = 8'($urandom);
    exp_q.push_back('{data: {b0, b1}, addr: '0, x: '0, y: '0});
    drive(1'b0, 1'b1, b0);
    drive(1'b0, 1'b1, b1);
    drive(1'b0, 1'b1, 8'($urandom));
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge pclk);
      if (pix.pix_valid === 1'b1) found = 1'b1;
    end
    check("valid_before_reset", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", pix.pix_valid, 0);
    check("async_rst_data", pix.pix_data, 0);
    check("async_rst_xy_addr", {pix.pix_x, pix.pix_y, pix.pix_addr}, 0);
    check("async_rst_flags", {pix.frame_start, pix.frame_done, pix.frame_err}, 0);
    cam_vsync = 1'b1; cam_href = 1'b0; cam_d = 8'h00;
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;

    set_lines(V, 2 * H);             send_frame(-1, 0, 1'b0);

    for (int k = 0; k < 20 && (exp_q.size() != 0 || exp_err_q.size() != 0); k++) @(negedge pclk);
    check("pixel_queue_drained", exp_q.size(), 0);
    check("err_queue_drained", exp_err_q.size(), 0);
    check("frame_start_count", starts_seen, starts_exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
